arb_rr4_decode: RTL and testbench



---
 rtl/arb_rr4_decode.sv | 128 ++++++++++++
 tb/tb_arb_rr4_decode.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/arb_rr4_decode.sv
// 4-requester round-robin arbiter with bounded hold, disable, and registered one-hot grant.
// Optional grant counter output enabled by defining ARB_GRANT_CNT_EN.
module arb_rr4_decode #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dis,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_vld
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0] grant_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  state_t     state, nxt_state;
  logic [1:0] last_id, nxt_last;
  logic [7:0] hold_cnt, nxt_hold;
  logic [1:0] nxt_id;
  logic       nxt_vld;
  logic [3:0] nxt_grant;
  logic [3:0] cand;
  logic       timeout, release_own, new_grant;

  // Smallest rotation offset (1..4) from last wins; offset 4 is the last owner itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] c, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (c[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    nxt_state   = state;
    nxt_id      = grant_id;
    nxt_vld     = grant_vld;
    nxt_last    = last_id;
    nxt_hold    = hold_cnt;
    new_grant   = 1'b0;
    cand        = req & ~(4'b0001 << grant_id);
    timeout     = HOLD_EN && (hold_cnt == HOLD_LIM);
    release_own = !req[grant_id] || timeout;
    case (state)
      IDLE: begin
        nxt_id  = 2'd0;
        nxt_vld = 1'b0;
        if (!dis && req != 4'b0000) begin
          nxt_state = BUSY;
          nxt_id    = rr_pick(req, last_id);
          nxt_vld   = 1'b1;
          nxt_hold  = 8'd1;
          new_grant = 1'b1;
        end
      end
      BUSY: begin
        if (dis) begin
          nxt_state = IDLE;
          nxt_id    = 2'd0;
          nxt_vld   = 1'b0;
          nxt_last  = grant_id;
          nxt_hold  = 8'd0;
        end else if (release_own) begin
          nxt_last = grant_id;
          if (cand != 4'b0000) begin
            nxt_id    = rr_pick(cand, grant_id);
            nxt_hold  = 8'd1;
            new_grant = 1'b1;
          end else if (timeout && req[grant_id]) begin
            // Sole requester timed out: re-grant in place, output unchanged.
            nxt_hold  = 8'd1;
            new_grant = 1'b1;
          end else begin
            nxt_state = IDLE;
            nxt_id    = 2'd0;
            nxt_vld   = 1'b0;
            nxt_hold  = 8'd0;
          end
        end else if (hold_cnt != 8'hFF) begin
          nxt_hold = hold_cnt + 8'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_dec
    assign nxt_grant[i] = nxt_vld && (nxt_id == 2'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      grant_id  <= 2'd0;
      grant_vld <= 1'b0;
      last_id   <= 2'd3;
      hold_cnt  <= 8'd0;
    end else begin
      state     <= nxt_state;
      grant     <= nxt_grant;
      grant_id  <= nxt_id;
      grant_vld <= nxt_vld;
      last_id   <= nxt_last;
      hold_cnt  <= nxt_hold;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                   grant_cnt <= 16'd0;
    else if (new_grant && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
  end
`else
  logic unused_new_grant;
  assign unused_new_grant = new_grant;
`endif

endmodule

// File: tb/tb_arb_rr4_decode.sv
// Bench for arb_rr4_decode: directed scenarios then random traffic, checked each cycle
// against an integer-level round-robin model.
module tb_arb_rr4_decode;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst, dis;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_vld;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt;
`endif

  arb_rr4_decode #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .dis(dis), .req(req),
    .grant(grant), .grant_id(grant_id), .grant_vld(grant_vld)
`ifdef ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: owner -1 means no grant.
  int m_owner = -1;
  int m_last  = 3;
  int m_hold  = 0;
  int m_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] c, input int from);
    for (int k = 1; k <= 4; k++) if (c[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic d, input logic [3:0] q);
    logic [3:0] c;
    bit tmo;
    if (r) begin
      m_owner = -1; m_last = 3; m_hold = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      if (!d && q != 0) begin
        m_owner = pick(q, m_last); m_hold = 1; m_cnt++;
      end
    end else if (d) begin
      m_last = m_owner; m_owner = -1;
    end else begin
      tmo = (MAX_HOLD != 0) && (m_hold == MAX_HOLD);
      if (!q[m_owner] || tmo) begin
        m_last = m_owner;
        c = q; c[m_owner] = 1'b0;
        if (c != 0) begin
          m_owner = pick(c, m_last); m_hold = 1; m_cnt++;
        end else if (tmo && q[m_owner]) begin
          m_hold = 1; m_cnt++;
        end else m_owner = -1;
      end else if (m_hold < 255) m_hold++;
    end
    if (m_cnt > 65535) m_cnt = 65535;
  endtask

  // Drive inputs, take one edge, then compare every output with the model.
  task automatic tick(input logic r, input logic d, input logic [3:0] q);
    logic [3:0] eg;
    rst = r; dis = d; req = q;
    @(posedge clk);
    model_step(r, d, q);
    #1;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("grant_vld", 32'(grant_vld), 32'(m_owner >= 0));
`ifdef ARB_GRANT_CNT_EN
    chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`endif
  endtask

  initial begin
    logic [3:0] rq;
    logic       rr, dd;
    rst = 1'b1; dis = 1'b0; req = 4'b0000;

    // Reset state
    tick(1, 0, 4'b0000);
    tick(1, 0, 4'b0000);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_vld", 32'(grant_vld), 32'd0);

    // First grant one cycle after request
    tick(0, 0, 4'b0001);
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_id", 32'(grant_id), 32'd0);
    chk("first_vld", 32'(grant_vld), 32'd1);

    // All requesting: MAX_HOLD cycles each, rotating with no gaps
    tick(1, 0, 4'b0000);
    for (int k = 0; k < 40; k++) begin
      tick(0, 0, 4'b1111);
      chk("rotate", 32'(grant), 32'(4'b0001 << ((k / MAX_HOLD) % 4)));
    end

    // Handoff on owner drop, then idle
    tick(1, 0, 4'b0000);
    tick(0, 0, 4'b0101);
    tick(0, 0, 4'b0101);
    tick(0, 0, 4'b0100);
    chk("handoff", 32'(grant), 32'h4);
    chk("handoff_id", 32'(grant_id), 32'd2);
    tick(0, 0, 4'b0000);
    chk("to_idle", 32'(grant), 32'h0);

    // Disable releases owner 1; search resumes at 2
    tick(1, 0, 4'b0000);
    tick(0, 0, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 4'b0010);
      chk("dis", 32'(grant), 32'h0);
    end
    tick(0, 0, 4'b0110);
    chk("after_dis", 32'(grant), 32'h4);

    // Sole requester held beyond MAX_HOLD stays granted
    tick(1, 0, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, 4'b0010);
      chk("sole_hold", 32'(grant), 32'h2);
    end
`ifdef ARB_GRANT_CNT_EN
    chk("sole_cnt", 32'(grant_cnt), 32'd3);
`endif

    // Reset mid-BUSY restarts priority at 0
    tick(1, 0, 4'b0000);
    tick(0, 0, 4'b0100);
    tick(0, 0, 4'b0100);
    tick(1, 0, 4'b0100);
    chk("rst_busy", 32'(grant), 32'h0);
    tick(0, 0, 4'b1001);
    chk("rst_prio", 32'(grant), 32'h1);

    // Random traffic with level-held requests
    rq = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      rr = ($urandom_range(0, 63) == 0);
      dd = ($urandom_range(0, 15) == 0);
      tick(rr, dd, rq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
